fetch_queue: RTL
================

Name: fetch_queue

Overview:
First-word-fall-through instruction queue between the fetch stage and the decode stage.
- Captures each fetched instruction word and its PC+4 from fetch.
- Presents them in order to decode using a valid/ready handshake.
- Decouples fetch from decode stalls and discards all queued entries on a taken branch (pc_src_M) flush.
- Also counts discarded entries for performance analysis.

Parameters:
N, 32, width of instruction word and PC+4 fields
DEPTH, 4, number of entries; power of two, at least 2
CW, 16, width of the saturating flush-discard counter

Ports:
ctrl_bus  interface (ctrl_bus_if.central)  -  carries clk and reset; one clock; reset is synchronous and active-high
inst_F  input  N  instruction word from fetch
pc_plus4_F  input  N  PC+4 from fetch
valid_F  input  1  fetch offers an entry this cycle
ready_F  output  1  queue accepts an entry; fetch holds its PC when low
flush  input  1  taken-branch flush (driven by pc_src_M)
inst_D  output  N  head instruction to decode
pc_plus4_D  output  N  head PC+4 to decode
valid_D  output  1  head entry is valid
ready_D  input  1  decode consumes the head this cycle
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
discard_cnt  output  CW  total entries discarded by flushes, saturating

Behaviour:
- State:
  - Storage array of DEPTH x (2N) bits.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy register count.
  - discard_cnt register.
- Reset (synchronous, active-high, sampled at the clk rising edge):
  - Pointers = 0, count = 0, discard_cnt = 0, all storage = 0.
  - Therefore valid_D = 0, inst_D = 0, pc_plus4_D = 0, ready_F = 1 in the cycle after reset.
  - Reset overrides flush and both handshakes, including mid-transfer.
- ready_F = (count != DEPTH). It depends only on registered state and never on ready_D.
- valid_D = (count != 0).
- inst_D and pc_plus4_D read combinationally from the entry at the read pointer (zero latency, first-word fall-through).
  - When valid_D = 0 the data outputs are don't-care.
- push = valid_F & ready_F & ~flush.
  - On push, the storage at the write pointer gets {inst_F, pc_plus4_F} and the write pointer increments.
- pop = valid_D & ready_D & ~flush.
  - On pop, the read pointer increments.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged. This is legal at any occupancy below DEPTH, including count = 1.
- Full (count = DEPTH): ready_F = 0, so no push even if decode pops in the same cycle. The slot reopens the next cycle.
- Empty (count = 0): valid_D = 0. A push becomes visible on valid_D the following cycle, so there is no bypass and minimum latency is 1 cycle.
- Flush takes priority over push and pop:
  - Next state: pointers = 0, count = 0. Storage contents are retained but invisible.
  - The entry offered on inst_F in the flush cycle is dropped. Decode's ready_D in that cycle does not consume anything.
  - discard_cnt += count (pre-flush occupancy), saturating at 2^CW - 1.
  - A flush with count = 0 leaves discard_cnt unchanged.
- Invariant: count never leaves 0..DEPTH. Pointers wrap silently from DEPTH-1 to 0.

Test Plan:
- Reset then idle: assert reset for 2 cycles with valid_F = 1 -> count = 0, valid_D = 0, ready_F = 1, discard_cnt = 0; no entry captured during reset.
- Fill to full: ready_D = 0; push inst_F = 0x00000013, 0x00100093, 0x00200113, 0x00300193 with pc_plus4_F = 0x4, 0x8, 0xC, 0x10 -> count = 4, ready_F = 0; a fifth push of 0x00400213 is not accepted; inst_D = 0x00000013, pc_plus4_D = 0x4.
- Drain and wrap: from full, ready_D = 1 with continuous pushes of 0x00500293, 0x00600313, ... -> outputs appear in exact push order across pointer wrap; count stays ≤ 4; no entry lost or duplicated over 20 cycles.
- Simultaneous push/pop at count = 1: head 0x00000013, push 0x00100093 with ready_D = 1 -> next cycle count = 1, inst_D = 0x00100093.
- Flush with 3 queued entries plus valid_F = 1 and ready_D = 1 in the same cycle -> next cycle count = 0, valid_D = 0, discard_cnt = 3; the offered entry is not captured.
- Discard counter saturation: with CW = 4, issue repeated flushes of a full queue (4 entries each) 5 times -> discard_cnt = 15 and holds at 15.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Control bus carrying the single clock and synchronous active-high reset
// shared by the fetch/decode pipeline blocks.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (input clk, input reset);
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Flushes discard all queued entries and add them to a saturating counter.
module fetch_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  ctrl_bus_if.central                   ctrl_bus,
  input  logic [N-1:0]                  inst_F,
  input  logic [N-1:0]                  pc_plus4_F,
  input  logic                          valid_F,
  output logic                          ready_F,
  input  logic                          flush,
  output logic [N-1:0]                  inst_D,
  output logic [N-1:0]                  pc_plus4_D,
  output logic                          valid_D,
  input  logic                          ready_D,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [CW-1:0]                 discard_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [2*N-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           pop;
  logic [CW:0]    disc_sum;
  logic [CW-1:0]  disc_next;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising clk edge; ready_F and valid_D come from registered
  // occupancy only, and a flush cancels both transfers in its cycle.
  assign ready_F    = (count != CNTW'(DEPTH));
  assign valid_D    = (count != '0);
  assign inst_D     = mem[rd_ptr][2*N-1:N];
  assign pc_plus4_D = mem[rd_ptr][N-1:0];
  assign push       = valid_F & ready_F & ~flush;
  assign pop        = valid_D & ready_D & ~flush;

  always_comb begin
    disc_sum  = {1'b0, discard_cnt} + {{(CW+1-CNTW){1'b0}}, count};
    disc_next = disc_sum[CW] ? {CW{1'b1}} : disc_sum[CW-1:0];
  end

  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      discard_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; resetting the pointers makes it unreachable.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      discard_cnt <= disc_next;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {inst_F, pc_plus4_F};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
